// File: rtl/rf_sched_pkg.sv
// Shared constants and state encoding for the register-file write scheduler.
// RF_SCHED_FIXED_PRIO_EN (optional) switches arbitration to fixed priority.
package rf_sched_pkg;

  localparam int RF_DW   = 16;
  localparam int RF_AW   = 4;
  localparam int RF_NREG = 2 ** RF_AW;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_sched_rr_arbiter.sv
// Request arbiter: one-hot grant plus encoded index, searching from ptr+1 with wrap.
// With RF_SCHED_FIXED_PRIO_EN defined the lowest index wins and ptr is ignored.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            any
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
`ifdef RF_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'(k);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = 3'(k);
        any      = 1'b1;
      end
    end
`else
    // Walk the ring starting just past the last winner; first hit wins.
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = 3'(idx);
        any      = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/rf_write_sched.sv
// Shares the register-file write port among NREQ writeback sources and zeroes the
// file after reset or on clear_req. RF_SCHED_FIXED_PRIO_EN selects fixed priority.
module rf_write_sched
  import rf_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_req,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      rf_D,
  output logic [AW-1:0]      rf_DA,
  output logic               rf_RW,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int NREG = 1 << AW;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [2:0]      arb_ptr;
  logic [NREQ-1:0] gnt;
  logic [2:0]      gnt_idx;
  logic            gnt_any;
  logic            arb_ok;
  logic            take;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (arb_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // A clear request pre-empts every requester in the cycle it is seen.
  assign arb_ok    = (state == ARB) && !clear_req;
  assign req_ready = arb_ok ? gnt : '0;
  assign take      = arb_ok && gnt_any;
  assign busy      = (state == CLEAR);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

`ifdef RF_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [2:0] rr_ptr;

  assign arb_ptr = rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    rr_ptr <= 3'(NREQ - 1);
    else if (take) rr_ptr <= gnt_idx;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      rf_D     <= '0;
      rf_DA    <= '0;
      rf_RW    <= 1'b0;
      grant_id <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rf_RW   <= 1'b1;
          rf_DA   <= clr_cnt;
          rf_D    <= '0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(NREG - 1)) state <= ARB;
        end
        default: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            rf_RW   <= 1'b0;
          end else if (take) begin
            rf_RW    <= 1'b1;
            rf_DA    <= sel_addr;
            rf_D     <= sel_data;
            grant_id <= gnt_idx;
          end else begin
            rf_RW <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Scoreboard bench for rf_write_sched: stimulus queues expected writes, a monitor
// pops and compares on every rf_RW cycle. Honours RF_SCHED_FIXED_PRIO_EN.
module tb_rf_write_sched;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 4;
`ifdef RF_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    g;
    logic          clr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear_req;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      rf_D;
  logic [AW-1:0]      rf_DA;
  logic               rf_RW;
  logic               busy;
  logic [2:0]         grant_id;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  rf_write_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_D      (rf_D),
    .rf_DA     (rf_DA),
    .rf_RW     (rf_RW),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] g);
    q.push_back('{a: a, d: d, g: g, clr: 1'b0});
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) q.push_back('{a: AW'(i), d: '0, g: '0, clr: 1'b1});
  endtask

  // n negedges during which the sequencer must be clearing and blocking requests.
  task automatic wait_clear(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("clr_busy", busy, 1);
      chk("clr_ready", req_ready, 0);
    end
  endtask

  // Monitor: every write the DUT issues must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (reset === 1'b1 && rf_RW === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got DA=%0h D=%0h gid=%0d, expected no write", rf_DA, rf_D, grant_id);
        end else begin
          e = q.pop_front();
          if (rf_DA !== e.a || rf_D !== e.d || (!e.clr && grant_id !== e.g)) begin
            n_err++;
            $display("FAIL write: got DA=%0h D=%0h gid=%0d, expected DA=%0h D=%0h gid=%0d",
                     rf_DA, rf_D, grant_id, e.a, e.d, e.g);
          end
        end
      end
    end
  end

  logic [NREQ-1:0] rr_tab [3];
  logic [NREQ-1:0] exp_rdy;
  int              gi;

  initial begin
    rr_tab[0] = 3'b001; rr_tab[1] = 3'b010; rr_tab[2] = 3'b100;
    reset = 1'b0; clear_req = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rw", rf_RW, 0);
    chk("rst_da", rf_DA, 0);
    chk("rst_d", rf_D, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);

    // power-on clear: 16 writes then idle
    @(negedge clk);
    reset = 1'b1;
    push_clear(16);
    wait_clear(15);
    @(negedge clk); #1;
    chk("clr_done_busy", busy, 0);
    @(negedge clk); #1;
    chk("idle_rw", rf_RW, 0);
    chk("idle_busy", busy, 0);

    // single request
    set_req(0, 4'd5, 16'hBEEF);
    req_valid = 3'b001;
    #1 chk("single_ready", req_ready, 3'b001);
    push(4'd5, 16'hBEEF, 3'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_rw", rf_RW, 1);
    chk("single_da", rf_DA, 5);
    chk("single_d", rf_D, 16'hBEEF);
    chk("single_gid", grant_id, 0);

    // move pointer to 2, then all three valid
    set_req(2, 4'd3, 16'h3333);
    req_valid = 3'b100;
    #1 chk("ptr2_ready", req_ready, 3'b100);
    push(4'd3, 16'h3333, 3'd2);
    @(negedge clk);
    set_req(0, 4'd10, 16'h1010);
    set_req(1, 4'd11, 16'h2121);
    set_req(2, 4'd12, 16'h3232);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      gi = FIXED ? 0 : k % 3;
      exp_rdy = rr_tab[gi];
      #1 chk("all_ready", req_ready, exp_rdy);
      push(AW'(10 + gi), (gi == 0) ? 16'h1010 : (gi == 1) ? 16'h2121 : 16'h3232, 3'(gi));
      @(negedge clk);
    end

    // two writers to the same register back to back: order decides the final value
    set_req(0, 4'd9, 16'h1111);
    set_req(1, 4'd9, 16'h2222);
    req_valid = 3'b011;
    #1 chk("same_ready0", req_ready, 3'b001);
    push(4'd9, 16'h1111, 3'd0);
    @(negedge clk);
    #1 chk("same_ready1", req_ready, FIXED ? 3'b001 : 3'b010);
    if (FIXED) push(4'd9, 16'h1111, 3'd0);
    else       push(4'd9, 16'h2222, 3'd1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);

    // clear request beats a pending requester, which is served after the clear
    set_req(1, 4'd7, 16'h7777);
    req_valid = 3'b010;
    clear_req = 1'b1;
    #1 chk("clrreq_ready", req_ready, 0);
    push_clear(16);
    @(negedge clk);
    clear_req = 1'b0;
    wait_clear(15);
    @(negedge clk); #1;
    chk("clrreq_grant", req_ready, 3'b010);
    push(4'd7, 16'h7777, 3'd1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);

    // reset during a grant cycle: the write is dropped
    set_req(0, 4'd4, 16'h4444);
    req_valid = 3'b001;
    #1 chk("rstg_ready", req_ready, 3'b001);
    #2 reset = 1'b0;
    #1;
    chk("rstg_rw", rf_RW, 0);
    chk("rstg_busy", busy, 1);
    chk("rstg_ready0", req_ready, 0);
    req_valid = '0;

    // reset mid-clear at clr_cnt=7, then a full clear from 0
    @(negedge clk);
    reset = 1'b1;
    push_clear(7);
    wait_clear(7);
    chk("mid_da", rf_DA, 6);
    chk("mid_rw", rf_RW, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rw", rf_RW, 0);
    chk("mid_rst_da", rf_DA, 0);
    @(negedge clk);
    reset = 1'b1;
    push_clear(16);
    wait_clear(15);
    @(negedge clk); #1;
    chk("reclr_busy", busy, 0);

    // pointer is back at NREQ-1 after reset
    set_req(1, 4'd15, 16'hFFFF);
    req_valid = 3'b010;
    #1 chk("post_ready", req_ready, 3'b010);
    push(4'd15, 16'hFFFF, 3'd1);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("sb_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Sequences and shares the single register-file write port (data, dest address, write-enable) among NREQ writeback requesters, e.g. ALU writeback, load unit and debug/host port.
- Also runs a clear sequence that zeroes all 16 registers after reset or on command, through the normal write port.
- Sits between the writeback sources and the register file; read ports are not touched.

Parameters:
- NREQ, 3, number of write requesters (2..8)
- DW, 16, data width
- AW, 4, register address width; NREG = 2**AW registers

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- clear_req  in  1  one-cycle pulse; starts a clear sequence
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  per-requester dest register, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  per-requester write data, requester i at [i*DW +: DW]
- req_ready  out  NREQ  grant; transfer occurs when req_valid[i] & req_ready[i]
- rf_D  out  DW  register-file write data
- rf_DA  out  AW  register-file write address
- rf_RW  out  1  register-file write enable
- busy  out  1  high while a clear sequence runs
- grant_id  out  3  index of the requester written last cycle (valid when rf_RW=1 and busy=0)

Behaviour:
- Reset asserted (reset=0): state=CLEAR, clr_cnt=0, rr_ptr=NREQ-1, rf_D=0, rf_DA=0, rf_RW=0, grant_id=0, req_ready=0, busy=1.
- rf_D, rf_DA, rf_RW and grant_id are registered outputs.
- req_ready is combinational from state, req_valid and rr_ptr.
- State CLEAR:
  - Each cycle, registers rf_RW=1, rf_DA=clr_cnt, rf_D=0, then clr_cnt++.
  - After clr_cnt=NREG-1 has been issued, moves to ARB.
  - Exactly NREG consecutive write cycles, so the first ARB grant can occur in cycle NREG after reset deassertion.
  - req_ready=0 and busy=1 throughout CLEAR.
  - clear_req during CLEAR is ignored; the count does not restart.
- State ARB:
  - busy=0. Priority search starts at (rr_ptr+1) mod NREQ and wraps.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0. At most one ready is high.
  - On a grant to i: next cycle rf_RW=1, rf_DA=req_addr[i], rf_D=req_data[i], grant_id=i, rr_ptr=i. Latency is 1 cycle from handshake to write.
  - With no valid request: next cycle rf_RW=0 and rf_D, rf_DA, grant_id hold their values. rr_ptr is unchanged.
  - A requester keeping valid high is re-arbitrated every cycle. Round robin guarantees service within NREQ cycles.
  - The same requester holding valid over back-to-back cycles with no competition is granted every cycle (full throughput, one write per cycle).
- clear_req=1 in ARB:
  - Clear wins over all requests: req_ready=0 that cycle and no transfer.
  - Next state is CLEAR with clr_cnt=0. The first clear write appears the following cycle.
  - Requests left pending must hold valid until re-granted after the clear completes.
- Two requesters targeting the same rf_DA in consecutive cycles: both writes are issued in grant order, so the later write wins in the register file.
- Reset asserted mid-clear or mid-write: outputs go immediately to reset values and any in-flight write is dropped. After deassertion a full clear runs again.
- No combinational path from req_* to rf_*.

Optional Feature:
- Macro RF_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest index with valid wins; rr_ptr is not implemented and grant_id has the same meaning.
- Undefined (default): round-robin as described above.

Decomposition:
- Package rf_sched_pkg holds DW, AW and NREG constants, plus the state enum {CLEAR, ARB} as a 1-bit typedef.
- One natural sub-module: rr_arbiter (NREQ-wide request vector plus pointer in, one-hot grant plus index out). It holds the fixed-priority variant under the macro.
- The top level keeps the FSM, clear counter and output registers.

Test Plan:
- Release reset, no requests -> 16 cycles with rf_RW=1, rf_DA=0..15, rf_D=0, busy=1; then busy=0, rf_RW=0.
- After clear, req_valid=3'b001, addr=5, data=16'hBEEF for 1 cycle -> req_ready[0]=1 that cycle; next cycle rf_RW=1, rf_DA=5, rf_D=16'hBEEF, grant_id=0.
- All three valid continuously with distinct addr/data, rr_ptr=2 -> grant order 0,1,2,0,1,2, one write per cycle, matching rf_DA/rf_D.
- clear_req pulsed while req_valid[1]=1 -> req_ready=0 that cycle; 16 clear writes; then requester 1 is granted and written.
- Reset asserted during a grant cycle and mid-clear at clr_cnt=7 -> rf_RW=0 immediately; after release, a full 0..15 clear restarts at 0.
- With RF_SCHED_FIXED_PRIO_EN defined, all valid continuously -> requester 0 granted every cycle; 1 and 2 starve.
